// File: rtl/sw_debounce_sync.sv
// ---------------------------------------------------------------------------
// sw_debounce_sync
//   Conditions a raw, bouncing board switch into the clean level `w` that the
//   serial pattern-detector FSM samples every clock. The raw input passes
//   through a SYNC_STAGES-deep synchronizer. A 4-state debounce FSM then
//   accepts a new level only after the synchronized input has held it for
//   DEBOUNCE_CYCLES consecutive cycles.
//
// Parameters
//   SYNC_STAGES      synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES  stable cycles required to accept a new level (>= 1)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-low reset
//   sw_raw  in   raw switch level (asynchronous, may bounce)
//   w       out  debounced, synchronized level
//   rise    out  1-cycle strobe in the cycle w goes 0->1
//   fall    out  1-cycle strobe in the cycle w goes 1->0
//   busy    out  high while a candidate transition is being qualified
//
// All outputs are registered and are cleared as soon as reset is asserted.
// ---------------------------------------------------------------------------
module sw_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic w,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LO    = 2'd0,
    ST_LO2HI = 2'd1,
    ST_HI    = 2'd2,
    ST_HI2LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // Synchronizer: bit 0 captures the asynchronous input; only the last
  // stage is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM. cnt is the number of consecutive cycles the candidate
  // level has been seen so far. Any bounce back to the current level drops
  // the candidate, so the next excursion starts counting again from 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LO;
      cnt   <= '0;
      w     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // Strobes are high for a single cycle unless a transition re-asserts them.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: begin
          w    <= 1'b0;
          busy <= 1'b0;
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= ST_HI;
              w     <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= ST_LO2HI;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end
        ST_LO2HI: begin
          if (!s) begin
            state <= ST_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            cnt   <= '0;
            w     <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HI: begin
          w    <= 1'b1;
          busy <= 1'b0;
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= ST_LO;
              w     <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= ST_HI2LO;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end
        ST_HI2LO: begin
          if (s) begin
            state <= ST_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            cnt   <= '0;
            w     <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          // Unreachable encodings fall back to the reset state.
          state <= ST_LO;
          cnt   <= '0;
          w     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
